// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port 0 = MEM stage, port 1 = loader/debug.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   pN_req/we/addr/wdata       request bundle of port N
//   pN_gnt                     combinational grant
//   pN_rvalid/rdata/err        registered response, one cycle after grant
//   stall                      port 0 waiting (to hazard unit)
//   mem_read/write/addr/wdata  memory strobes, address and store data
//   mem_rdata                  combinational memory read data
module dmem_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        stall,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    ERR
  } state_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  req_t        rq [2];
  req_t        sel;
  logic [1:0]  gnt;
  logic [1:0]  legal;
  logic        sel_ok;
  logic        act;
  logic [3:0]  starve_q;
  logic [3:0]  starve_d;
  logic        starved;
  state_t      state_q [2];
  state_t      state_d [2];
  logic [31:0] rdata_q [2];

  always_comb begin
    rq[0] = '{req: p0_req, we: p0_we,
              addr: p0_addr, wdata: p0_wdata};
    rq[1] = '{req: p1_req, we: p1_we,
              addr: p1_addr, wdata: p1_wdata};
  end

  assign starved = (starve_q == LIMIT);

  // Grants are forced low while reset is held so
  // nothing reaches the memory during reset.
  always_comb begin
    gnt = '0;
    if (rst_n) begin
      gnt[1] = rq[1].req & (~rq[0].req | starved);
      gnt[0] = rq[0].req & ~gnt[1];
    end
  end

  always_comb begin
    legal = '0;
    for (int i = 0; i < 2; i++) begin
      legal[i] = (rq[i].addr[1:0] == 2'b00) &&
                 (rq[i].addr[31:ADDR_W+2] == '0);
    end
  end

  assign sel    = gnt[1] ? rq[1] : rq[0];
  assign sel_ok = gnt[1] ? legal[1] : legal[0];
  assign act    = (|gnt) & sel_ok;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      act & sel.we: begin
        mem_write = 1'b1;
        mem_addr  = {sel.addr[31:2], 2'b00};
        mem_wdata = sel.wdata;
      end
      act & ~sel.we: begin
        mem_read = 1'b1;
        mem_addr = {sel.addr[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  // Counts consecutive port-1 losses; saturates so
  // port 1 keeps priority until it is served.
  always_comb begin
    starve_d = '0;
    if (rq[1].req & ~gnt[1]) begin
      starve_d = starved ? starve_q
                         : starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = IDLE;
      if (gnt[i]) begin
        state_d[i] = legal[i] ? RESP : ERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        rdata_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        if (gnt[i] & legal[i] & ~rq[i].we) begin
          rdata_q[i] <= mem_rdata;
        end
      end
    end
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = (state_q[0] == RESP);
  assign p1_rvalid = (state_q[1] == RESP);
  assign p0_err    = (state_q[0] == ERR);
  assign p1_err    = (state_q[1] == ERR);
  assign p0_rdata  = rdata_q[0];
  assign p1_rdata  = rdata_q[1];
  assign stall     = rst_n & p0_req & ~gnt[0];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed steps plus
// randomized traffic against a reference model.
module tb_dmem_arbiter;

  localparam int ADDR_W = 7;
  localparam int LIMIT  = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err;
  logic        p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        stall, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  // reference model state
  int          losses;
  bit          ev0, ev1, ee0, ee1;
  logic [31:0] erd0, erd1;
  bit          g0_m, g1_m;
  logic        obs_g1, obs_stall;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[ADDR_W+1:2]];

  always @(posedge clk)
    if (mem_write) mem[mem_addr[ADDR_W+1:2]] <= mem_wdata;

  dmem_arbiter #(
    .ADDR_W(ADDR_W),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .stall(stall), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 4 * DEPTH);
  endfunction

  function automatic logic [31:0] rnd_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0)
      return $urandom_range(0, DEPTH - 1) * 4
             + $urandom_range(1, 3);
    if (k == 1)
      return (4 * DEPTH + $urandom_range(0, 4000) * 4)
             | ($urandom_range(0, 1) << 31);
    return $urandom_range(0, DEPTH - 1) * 4;
  endfunction

  task automatic model_reset();
    losses = 0;
    ev0 = 0; ev1 = 0; ee0 = 0; ee1 = 0;
    erd0 = '0; erd1 = '0;
  endtask

  // One clock cycle: inputs already driven. Checks the
  // combinational side at the negedge, the response
  // side just after the following posedge.
  task automatic cycle();
    bit w0, w1, l0, l1, rd, wr;
    logic [31:0] ea, ed;
    @(negedge clk);
    w1 = p1_req && (!p0_req || losses >= LIMIT);
    w0 = p0_req && !w1;
    l0 = legal(p0_addr);
    l1 = legal(p1_addr);
    rd = (w0 && l0 && !p0_we) || (w1 && l1 && !p1_we);
    wr = (w0 && l0 && p0_we) || (w1 && l1 && p1_we);
    ea = w1 ? p1_addr & ~32'd3 : p0_addr & ~32'd3;
    ed = w1 ? p1_wdata : p0_wdata;
    chk("p0_gnt", 32'(p0_gnt), 32'(w0));
    chk("p1_gnt", 32'(p1_gnt), 32'(w1));
    chk("mem_read", 32'(mem_read), 32'(rd));
    chk("mem_write", 32'(mem_write), 32'(wr));
    chk("stall", 32'(stall), 32'(p0_req && !w0));
    if (rd || wr) chk("mem_addr", mem_addr, ea);
    if (wr) chk("mem_wdata", mem_wdata, ed);
    obs_g1 = p1_gnt;
    obs_stall = stall;
    g0_m = w0;
    g1_m = w1;
    ev0 = w0 && l0; ee0 = w0 && !l0;
    ev1 = w1 && l1; ee1 = w1 && !l1;
    if (w0 && l0 && !p0_we)
      erd0 = ref_mem[p0_addr / 4];
    if (w1 && l1 && !p1_we)
      erd1 = ref_mem[p1_addr / 4];
    if (wr) ref_mem[ea / 4] = ed;
    if (p1_req && !w1)
      losses = (losses < LIMIT) ? losses + 1 : LIMIT;
    else
      losses = 0;
    @(posedge clk);
    #1;
    chk("p0_rvalid", 32'(p0_rvalid), 32'(ev0));
    chk("p1_rvalid", 32'(p1_rvalid), 32'(ev1));
    chk("p0_err", 32'(p0_err), 32'(ee0));
    chk("p1_err", 32'(p1_err), 32'(ee1));
    chk("p0_rdata", p0_rdata, erd0);
    chk("p1_rdata", p1_rdata, erd1);
  endtask

  task automatic set0(input logic r, input logic w,
                      input logic [31:0] a,
                      input logic [31:0] d);
    p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d;
  endtask

  task automatic set1(input logic r, input logic w,
                      input logic [31:0] a,
                      input logic [31:0] d);
    p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d;
  endtask

  task automatic reset_outs(input string tag);
    chk({tag, "_g0"}, 32'(p0_gnt), 32'd0);
    chk({tag, "_g1"}, 32'(p1_gnt), 32'd0);
    chk({tag, "_rd"}, 32'(mem_read), 32'd0);
    chk({tag, "_wr"}, 32'(mem_write), 32'd0);
    chk({tag, "_v0"}, 32'(p0_rvalid), 32'd0);
    chk({tag, "_v1"}, 32'(p1_rvalid), 32'd0);
    chk({tag, "_e0"}, 32'(p0_err), 32'd0);
    chk({tag, "_e1"}, 32'(p1_err), 32'd0);
    chk({tag, "_d0"}, p0_rdata, 32'd0);
    chk({tag, "_d1"}, p1_rdata, 32'd0);
  endtask

  initial begin
    int n1, ns;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = i * 10;
      ref_mem[i] = i * 10;
    end
    model_reset();
    g0_m = 0; g1_m = 0;

    // 1: reset held with port 0 requesting
    rst_n = 1'b0;
    set0(1'b1, 1'b0, 32'h0, 32'h0);
    set1(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_outs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // 2: load 0x14 -> 50
    set0(1'b1, 1'b0, 32'h14, 32'h0);
    cycle();
    chk("t2_rdata", p0_rdata, 32'd50);
    chk("t2_rvalid", 32'(p0_rvalid), 32'd1);

    // 3: store 0x1234 to 0x08, then load it back
    set0(1'b1, 1'b1, 32'h08, 32'h1234);
    cycle();
    set0(1'b1, 1'b0, 32'h08, 32'h0);
    cycle();
    chk("t3_rdata", p0_rdata, 32'h1234);
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    cycle();

    // 4: both ports requesting continuously
    set0(1'b1, 1'b0, 32'h10, 32'h0);
    set1(1'b1, 1'b0, 32'h20, 32'h0);
    n1 = 0;
    ns = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (obs_g1) n1++;
      if (obs_stall) ns++;
    end
    chk("t4_p1_grants", 32'(n1), 32'd4);
    chk("t4_stalls", 32'(ns), 32'd4);
    set0(1'b0, 1'b0, 32'h0, 32'h0);

    // 5: misaligned and out-of-range on port 1
    set1(1'b1, 1'b0, 32'h06, 32'h0);
    cycle();
    chk("t5_err_mis", 32'(p1_err), 32'd1);
    set1(1'b1, 1'b0, 32'h200, 32'h0);
    cycle();
    chk("t5_err_oor", 32'(p1_err), 32'd1);
    chk("t5_rvalid", 32'(p1_rvalid), 32'd0);
    set1(1'b0, 1'b0, 32'h0, 32'h0);
    cycle();

    // 6: reset between grant and response
    set0(1'b1, 1'b0, 32'h14, 32'h0);
    cycle();
    set0(1'b1, 1'b0, 32'h18, 32'h0);
    @(negedge clk);
    chk("t6_gnt", 32'(p0_gnt), 32'd1);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("t6_rvalid", 32'(p0_rvalid), 32'd0);
    chk("t6_rdata", p0_rdata, 32'd0);
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    chk("t6_after", 32'(p0_rvalid), 32'd0);

    // randomized traffic; losers keep their request
    g0_m = 1; g1_m = 1;
    for (int c = 0; c < 500; c++) begin
      if (!p0_req || g0_m || $urandom_range(0, 19) == 0)
        set0(1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 1)),
             rnd_addr(), $urandom());
      if (!p1_req || g1_m || $urandom_range(0, 19) == 0)
        set1(1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 1)),
             rnd_addr(), $urandom());
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
